// File: rtl/lcd_cfah_bus_pkg.sv
// Shared types, LCD bus timing constants and cycle-conversion helpers for the CFAH1602B bus sequencer.
// LCD_CFAH_RD_SYNC_EN lengthens the E pulse to cover the read-data synchronizer.
package lcd_cfah_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_RECOVER,
    ST_DONE
  } state_t;

  localparam int T_AS  = 60;
  localparam int T_PW  = 480;
  localparam int T_H   = 20;
  localparam int T_CYC = 1000;

`ifdef LCD_CFAH_RD_SYNC_EN
  localparam int PW_EXT = 2;
`else
  localparam int PW_EXT = 0;
`endif

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int ns2cyc(input int t_ns, input int clk_ns);
    return max2(1, (t_ns + clk_ns - 1) / clk_ns);
  endfunction

  // Recovery pads the unextended E cycle out to tcycE.
  function automatic int rec_cyc(input int n_cyc, input int n_as, input int n_pw, input int n_h);
    return max2(1, n_cyc - n_as - n_pw - n_h);
  endfunction

endpackage

// File: rtl/lcd_cfah_tcnt.sv
// Loadable down-counter with a registered terminal-count (zero) flag; holds at zero.
module lcd_cfah_tcnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      zero <= 1'b1;
    end else if (load) begin
      cnt  <= load_val;
      zero <= (load_val == '0);
    end else if (cnt != '0) begin
      cnt  <= cnt - W'(1);
      zero <= (cnt == W'(1));
    end
  end

endmodule

// File: rtl/lcd_cfah_bus_ctrl.sv
// One-shot RS/RW/E bus cycle for an HD44780-style LCD; outputs registered from the next state.
// States: IDLE wait start | SETUP addr setup | EN_HI E high | HOLD addr/data hold | RECOVER tcycE pad | DONE done pulse. Macro: LCD_CFAH_RD_SYNC_EN.
module lcd_cfah_bus_ctrl
  import lcd_cfah_bus_pkg::*;
#(
  parameter int   G_CLK_PERIOD_NS      = 20,
  parameter logic G_BIDIR_SEL_POLARITY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_lcd_data,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic       i_start,
  output logic [7:0] o_lcd_wdata,
  output logic [7:0] o_lcd_rdata,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_bidir_sel,
  output logic       o_done
);

  localparam int N_AS  = ns2cyc(T_AS, G_CLK_PERIOD_NS);
  localparam int N_PW  = ns2cyc(T_PW, G_CLK_PERIOD_NS);
  localparam int N_H   = ns2cyc(T_H, G_CLK_PERIOD_NS);
  localparam int N_CYC = ns2cyc(T_CYC, G_CLK_PERIOD_NS);
  localparam int N_REC = rec_cyc(N_CYC, N_AS, N_PW, N_H);
  localparam int N_EN  = N_PW + PW_EXT;
  localparam int N_MAX = max2(max2(N_AS, N_EN), max2(N_H, N_REC));
  localparam int CNT_W = $clog2(N_MAX) + 1;

  localparam logic [CNT_W-1:0] LD_AS  = CNT_W'(N_AS - 1);
  localparam logic [CNT_W-1:0] LD_EN  = CNT_W'(N_EN - 1);
  localparam logic [CNT_W-1:0] LD_H   = CNT_W'(N_H - 1);
  localparam logic [CNT_W-1:0] LD_REC = CNT_W'(N_REC - 1);

  localparam logic BIDIR_ON  = G_BIDIR_SEL_POLARITY;
  localparam logic BIDIR_OFF = ~G_BIDIR_SEL_POLARITY;

  state_t           state_q, state_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             rw_lat, rw_lat_d;
  logic             accept, drive_phase, capture;
  logic [7:0]       rd_sample;
  logic [7:0]       wdata_d;
  logic             rs_d, rw_d, en_d, bidir_d, done_d;

  lcd_cfah_tcnt #(.W(CNT_W)) u_tcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

`ifdef LCD_CFAH_RD_SYNC_EN
  logic [7:0] rd_meta, rd_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_meta <= '0;
      rd_sync <= '0;
    end else begin
      rd_meta <= i_lcd_data;
      rd_sync <= rd_meta;
    end
  end

  assign rd_sample = rd_sync;
`else
  assign rd_sample = i_lcd_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: if (i_start) begin
        state_d  = ST_SETUP;
        cnt_load = 1'b1;
        cnt_val  = LD_AS;
      end
      ST_SETUP: if (cnt_zero) begin
        state_d  = ST_EN_HI;
        cnt_load = 1'b1;
        cnt_val  = LD_EN;
      end
      ST_EN_HI: if (cnt_zero) begin
        state_d  = ST_HOLD;
        cnt_load = 1'b1;
        cnt_val  = LD_H;
      end
      ST_HOLD: if (cnt_zero) begin
        state_d  = ST_RECOVER;
        cnt_load = 1'b1;
        cnt_val  = LD_REC;
      end
      ST_RECOVER: if (cnt_zero) begin
        state_d  = ST_DONE;
        cnt_load = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // o_lcd_rs and o_lcd_wdata double as the request latches, so they simply hold outside acceptance.
  always_comb begin
    accept      = (state_q == ST_IDLE) && i_start;
    rw_lat_d    = accept ? i_rw : rw_lat;
    rs_d        = accept ? i_rs : o_lcd_rs;
    wdata_d     = (accept && !i_rw) ? i_wdata : o_lcd_wdata;
    drive_phase = (state_d == ST_SETUP) || (state_d == ST_EN_HI) || (state_d == ST_HOLD);
    rw_d        = drive_phase && rw_lat_d;
    en_d        = (state_d == ST_EN_HI);
    bidir_d     = (drive_phase && !rw_lat_d) ? BIDIR_ON : BIDIR_OFF;
    done_d      = (state_d == ST_DONE);
    capture     = (state_q == ST_EN_HI) && cnt_zero && rw_lat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_lat      <= 1'b0;
      o_lcd_rs    <= 1'b0;
      o_lcd_rw    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_lcd_wdata <= '0;
      o_lcd_rdata <= '0;
      o_bidir_sel <= BIDIR_OFF;
      o_done      <= 1'b0;
    end else begin
      rw_lat      <= rw_lat_d;
      o_lcd_rs    <= rs_d;
      o_lcd_rw    <= rw_d;
      o_lcd_en    <= en_d;
      o_lcd_wdata <= wdata_d;
      o_bidir_sel <= bidir_d;
      o_done      <= done_d;
      if (capture) o_lcd_rdata <= rd_sample;
    end
  end

endmodule

// File: tb/tb_lcd_cfah_bus_ctrl.sv
// Directed bench for lcd_cfah_bus_ctrl: write, read, dropped starts, async reset abort, both bidir polarities.
module tb_lcd_cfah_bus_ctrl;

`ifdef LCD_CFAH_RD_SYNC_EN
  localparam int EXP_PW = 26;
`else
  localparam int EXP_PW = 24;
`endif
  localparam int EXP_EN_FIRST = 4;
  localparam int EXP_DRV      = 3 + EXP_PW + 1;
  localparam int EXP_DONE     = 3 + EXP_PW + 1 + 22 + 1;
  localparam int WIN          = 70;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] lcd_data = 8'hFF;
  logic       rs = 1'b0;
  logic       rw = 1'b0;
  logic       start = 1'b0;

  logic [7:0] lcd_wdata, lcd_rdata, p0_lcd_wdata, p0_lcd_rdata;
  logic       lcd_rw, lcd_en, lcd_rs, bidir_sel, done;
  logic       p0_lcd_rw, p0_lcd_en, p0_lcd_rs, p0_bidir_sel, p0_done;

  int checks = 0;
  int failures = 0;

  int en_first, en_cnt, en_rises, done_cyc, done_cnt, act0, act1, wbad, rwbad;
  logic rs_at1, rw_at1, en_prev;
  logic [7:0] rdata_fall;

  always #10 clk = ~clk;

  lcd_cfah_bus_ctrl #(.G_CLK_PERIOD_NS(20), .G_BIDIR_SEL_POLARITY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_wdata(wdata), .i_lcd_data(lcd_data), .i_rs(rs), .i_rw(rw),
    .i_start(start), .o_lcd_wdata(lcd_wdata), .o_lcd_rdata(lcd_rdata), .o_lcd_rw(lcd_rw),
    .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs), .o_bidir_sel(bidir_sel), .o_done(done)
  );

  lcd_cfah_bus_ctrl #(.G_CLK_PERIOD_NS(20), .G_BIDIR_SEL_POLARITY(1'b0)) dut_p0 (
    .clk(clk), .rst_n(rst_n), .i_wdata(wdata), .i_lcd_data(lcd_data), .i_rs(rs), .i_rw(rw),
    .i_start(start), .o_lcd_wdata(p0_lcd_wdata), .o_lcd_rdata(p0_lcd_rdata), .o_lcd_rw(p0_lcd_rw),
    .o_lcd_en(p0_lcd_en), .o_lcd_rs(p0_lcd_rs), .o_bidir_sel(p0_bidir_sel), .o_done(p0_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request and observes WIN cycles; cycle k is sampled at the k-th falling edge after acceptance.
  task automatic run_xfer(input logic x_rs, input logic x_rw, input logic [7:0] x_wd,
                          input logic [7:0] x_rd, input int again_at);
    en_first = 0; en_cnt = 0; en_rises = 0; done_cyc = 0; done_cnt = 0;
    act0 = 0; act1 = 0; wbad = 0; rwbad = 0; en_prev = 1'b0; rdata_fall = 8'h00;
    rs_at1 = 1'b0; rw_at1 = 1'b0;
    @(negedge clk);
    rs = x_rs; rw = x_rw; wdata = x_wd; start = 1'b1;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      start = (k == again_at);
      if (k == 1) begin
        rs_at1 = lcd_rs; rw_at1 = lcd_rw;
        rs = ~x_rs; rw = ~x_rw; wdata = ~x_wd;
      end
      if (lcd_en) begin
        if (en_first == 0) en_first = k;
        en_cnt++;
        if (!en_prev) en_rises++;
        if (lcd_rw !== x_rw) rwbad++;
      end
      if (en_prev && !lcd_en) rdata_fall = lcd_rdata;
      en_prev = lcd_en;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (bidir_sel) begin
        act0++;
        if (lcd_wdata !== x_wd) wbad++;
      end
      if (!p0_bidir_sel) act1++;
      lcd_data = lcd_en ? x_rd : 8'hFF;
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wdata", 32'(lcd_wdata), 32'h00);
    check("rst_rdata", 32'(lcd_rdata), 32'h00);
    check("rst_rw", 32'(lcd_rw), 32'h0);
    check("rst_en", 32'(lcd_en), 32'h0);
    check("rst_rs", 32'(lcd_rs), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_bidir_p1", 32'(bidir_sel), 32'h0);
    check("rst_bidir_p0", 32'(p0_bidir_sel), 32'h1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(1'b1, 1'b0, 8'h41, 8'hC3, 0);
    check("wr_en_first", 32'(en_first), 32'(EXP_EN_FIRST));
    check("wr_en_cnt", 32'(en_cnt), 32'(EXP_PW));
    check("wr_en_rises", 32'(en_rises), 32'd1);
    check("wr_done_cyc", 32'(done_cyc), 32'(EXP_DONE));
    check("wr_done_cnt", 32'(done_cnt), 32'd1);
    check("wr_rs_setup", 32'(rs_at1), 32'h1);
    check("wr_rw_setup", 32'(rw_at1), 32'h0);
    check("wr_rw_en", 32'(rwbad), 32'd0);
    check("wr_bidir_p1", 32'(act0), 32'(EXP_DRV));
    check("wr_bidir_p0", 32'(act1), 32'(EXP_DRV));
    check("wr_wdata_drv", 32'(wbad), 32'd0);
    check("wr_wdata_hold", 32'(lcd_wdata), 32'h41);
    check("wr_rdata_keep", 32'(lcd_rdata), 32'h00);

    run_xfer(1'b0, 1'b1, 8'h99, 8'h80, 0);
    check("rd_en_cnt", 32'(en_cnt), 32'(EXP_PW));
    check("rd_done_cyc", 32'(done_cyc), 32'(EXP_DONE));
    check("rd_done_cnt", 32'(done_cnt), 32'd1);
    check("rd_rs_setup", 32'(rs_at1), 32'h0);
    check("rd_rw_setup", 32'(rw_at1), 32'h1);
    check("rd_rw_en", 32'(rwbad), 32'd0);
    check("rd_bidir_p1", 32'(act0), 32'd0);
    check("rd_bidir_p0", 32'(act1), 32'd0);
    check("rd_rdata_fall", 32'(rdata_fall), 32'h80);
    check("rd_rdata_hold", 32'(lcd_rdata), 32'h80);
    check("rd_wdata_keep", 32'(lcd_wdata), 32'h41);

    run_xfer(1'b1, 1'b0, 8'h42, 8'hFF, 15);
    check("b2b_en_rises", 32'(en_rises), 32'd1);
    check("b2b_done_cnt", 32'(done_cnt), 32'd1);
    check("b2b_done_cyc", 32'(done_cyc), 32'(EXP_DONE));

    run_xfer(1'b0, 1'b0, 8'h43, 8'hFF, EXP_DONE);
    check("dn_start_rises", 32'(en_rises), 32'd1);
    check("dn_start_done", 32'(done_cnt), 32'd1);
    check("dn_start_wdata", 32'(lcd_wdata), 32'h43);
    check("dn_start_rdata", 32'(lcd_rdata), 32'h80);

    run_xfer(1'b1, 1'b1, 8'h00, 8'h5A, 0);
    check("rd2_done_cyc", 32'(done_cyc), 32'(EXP_DONE));
    check("rd2_rdata", 32'(lcd_rdata), 32'h5A);
    check("rd2_wdata_keep", 32'(lcd_wdata), 32'h43);

    @(negedge clk);
    rs = 1'b1; rw = 1'b0; wdata = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_pre_en", 32'(lcd_en), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_en", 32'(lcd_en), 32'h0);
    check("abort_bidir_p1", 32'(bidir_sel), 32'h0);
    check("abort_bidir_p0", 32'(p0_bidir_sel), 32'h1);
    check("abort_wdata", 32'(lcd_wdata), 32'h00);
    check("abort_rdata", 32'(lcd_rdata), 32'h00);
    check("abort_rs_rw", 32'({lcd_rs, lcd_rw}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0; en_rises = 0;
    for (int k = 0; k < WIN; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (lcd_en) en_rises++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_no_en", 32'(en_rises), 32'd0);

    run_xfer(1'b1, 1'b0, 8'h33, 8'hFF, 0);
    check("post_done_cyc", 32'(done_cyc), 32'(EXP_DONE));
    check("post_en_cnt", 32'(en_cnt), 32'(EXP_PW));
    check("post_wdata", 32'(lcd_wdata), 32'h33);
    check("post_bidir_p0", 32'(act1), 32'(EXP_DRV));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
